adc_reader: RTL and testbench

Initiator-side controller for the team's start/EOC/OE ADC conversion protocol.
- Issues a start pulse and tracks the ADC's EOC busy/done sequence.
- Pulses OE to read the result and presents the 12-bit sample to downstream logic (PID loop) as a one-cycle valid strobe.
- Conversions are triggered by an external request or by an internal periodic sampler.
- Protocol errors are reported as timeout and overrun flags.

---
 rtl/acc_pid_pkg.sv | 17 +
 rtl/adc_reader_if.sv | 32 +++
 rtl/adc_trig_gen.sv | 40 ++++
 rtl/adc_reader.sv | 171 +++++++++++++++++
 tb/tb_adc_reader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pid_pkg.sv
// rtl/acc_pid_pkg.sv - shared ADC reader types and constants
// Purpose: state encoding and sample width shared by the ADC reader block.
// Ports: none (package).
package acc_pid_pkg;

  localparam int ADC_DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    READ,
    GAP
  } adc_state_e;

endpackage

// File: rtl/adc_reader_if.sv
// rtl/adc_reader_if.sv - start/EOC/OE ADC conversion bus
// Purpose: groups the ADC-side handshake and data lines.
// Signals:
//   start   - conversion request (initiator -> ADC)
//   oe      - output enable (initiator -> ADC)
//   eoc     - end of conversion, high = idle/done (ADC -> initiator)
//   adc_din - parallel sample, valid while oe high (ADC -> initiator)
// Modports: master = initiator (adc_reader), slave = ADC device.
interface adc_reader_if #(
  parameter int DATA_W = 12
);

  logic              start;
  logic              oe;
  logic              eoc;
  logic [DATA_W-1:0] adc_din;

  modport master (
    output start,
    output oe,
    input  eoc,
    input  adc_din
  );

  modport slave (
    input  start,
    input  oe,
    output eoc,
    output adc_din
  );

endinterface

// File: rtl/adc_trig_gen.sv
// rtl/adc_trig_gen.sv - periodic conversion tick generator
// Purpose: emits a one-cycle tick every PERIOD cycles while auto_en_i is high.
// Ports:
//   clk       - system clock
//   rstn      - synchronous active-low reset
//   auto_en_i - enable; low clears the period counter
//   tick_o    - registered one-cycle tick
module adc_trig_gen #(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic auto_en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // Counter restarts from zero whenever auto_en drops, so the first tick
  // lands PERIOD cycles after auto_en rises.
  always_ff @(posedge clk) begin
    if (!rstn || !auto_en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/adc_reader.sv
// rtl/adc_reader.sv - start/EOC/OE ADC conversion initiator
// Purpose: issues start, tracks the EOC busy/done sequence, reads the sample
// with OE and presents it as a one-cycle strobe; flags timeouts and overruns.
// Ports:
//   clk, rstn   - clock, synchronous active-low reset
//   trig        - single-cycle conversion request
//   auto_en     - enable periodic self-triggering every PERIOD cycles
//   clr         - clears sticky timeout_err and overrun
//   adc         - ADC bus (start/oe out, eoc/adc_din in)
//   dout        - last captured sample
//   dout_valid  - one-cycle strobe, dout updated this cycle
//   busy        - high whenever not IDLE
//   timeout_err - sticky, EOC sequence did not complete in time
//   overrun     - sticky, request arrived while busy
module adc_reader
  import acc_pid_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int START_CYC   = 2,
  parameter int OE_CYC      = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int PERIOD      = 1000,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              trig,
  input  logic              auto_en,
  input  logic              clr,
  adc_reader_if.master      adc,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] OE_LAST    = CNT_W'(OE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  adc_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              start_q;
  logic              oe_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              busy_q;
  logic              timeout_err_q;
  logic              timeout_err_d;
  logic              overrun_q;
  logic              overrun_d;

  logic auto_tick;
  logic req;
  logic to_hit;

  adc_trig_gen #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_trig_gen (
    .clk       (clk),
    .rstn      (rstn),
    .auto_en_i (auto_en),
    .tick_o    (auto_tick)
  );

  always_comb begin
    req = trig | auto_tick;
    // Timeout only fires when the awaited EOC edge is not present this cycle;
    // completion wins over timeout on the same edge. The >= compare keeps the
    // limit effective across the WAIT_BUSY -> WAIT_DONE hand-over.
    to_hit = (((state_q == WAIT_BUSY) && adc.eoc) ||
              ((state_q == WAIT_DONE) && !adc.eoc)) && (cnt_q >= TO_LAST);
    // Set beats clear when both happen in the same cycle.
    overrun_d     = (req && (state_q != IDLE)) ? 1'b1 :
                    clr                        ? 1'b0 : overrun_q;
    timeout_err_d = to_hit ? 1'b1 : clr ? 1'b0 : timeout_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      oe_q          <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      dout_valid_q  <= 1'b0;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == START_LAST) begin
            start_q <= 1'b0;
            state_q <= WAIT_BUSY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_BUSY: begin
          if (!adc.eoc) begin
            state_q <= WAIT_DONE;
            cnt_q   <= cnt_q + CNT_W'(1);
          end else if (to_hit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (adc.eoc) begin
            state_q <= READ;
            oe_q    <= 1'b1;
            cnt_q   <= '0;
          end else if (to_hit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        READ: begin
          // Capture on the edge that ends the last oe-high cycle.
          if (cnt_q == OE_LAST) begin
            oe_q         <= 1'b0;
            dout_q       <= adc.adc_din;
            dout_valid_q <= 1'b1;
            state_q      <= GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          // One oe-low cycle so the ADC settles before any new start.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          start_q <= 1'b0;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc.start   = start_q;
  assign adc.oe      = oe_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_reader.sv
// tb/tb_adc_reader.sv - self-checking bench for adc_reader
module tb_adc_reader;
  import acc_pid_pkg::*;

  localparam int DW          = ADC_DATA_W;
  localparam int START_CYC   = 2;
  localparam int OE_CYC      = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int PERIOD      = 100;
  localparam int CNT_W       = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, trig, auto_en, clr;
  logic [DW-1:0] dout;
  logic          dout_valid, busy, timeout_err, overrun;

  adc_reader_if #(.DATA_W(DW)) aif ();

  adc_reader #(
    .DATA_W(DW), .START_CYC(START_CYC), .OE_CYC(OE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .PERIOD(PERIOD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .trig(trig), .auto_en(auto_en), .clr(clr),
    .adc(aif), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ADC device: eoc drops one cycle after start falls, stays low conv_len
  // cycles, then returns high; data is driven only while oe is high.
  logic          adc_stuck = 1'b0;
  int            conv_len  = 10;
  logic [DW-1:0] adc_val   = '0;
  initial begin
    bit prev_start;
    bit pend;
    int low_left;
    prev_start = 0; pend = 0; low_left = 0;
    aif.eoc = 1'b1;
    aif.adc_din = '0;
    forever begin
      @(posedge clk); #1;
      aif.adc_din = aif.oe ? adc_val : '0;
      if (adc_stuck) begin
        aif.eoc = 1'b1; pend = 0; low_left = 0;
      end else if (prev_start && !aif.start) begin
        pend = 1;
      end else if (pend) begin
        aif.eoc = 1'b0; low_left = conv_len; pend = 0;
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) aif.eoc = 1'b1;
      end
      prev_start = aif.start;
    end
  end

  // Reference model: each conversion is described by the edge it was accepted
  // on and the edges where eoc was seen low and then high; all outputs follow
  // from those timestamps.
  int            edge_n = 0;
  int            run = 0;
  bit            m_busy = 0;
  int            acc_n = 0, low_n = -1, high_n = -1;
  bit            model_live = 0;
  bit            e_start = 0, e_oe = 0, e_valid = 0, e_busy = 0, e_to = 0, e_ovr = 0;
  logic [DW-1:0] e_dout = '0;
  bit            m_tick, m_req, m_was_busy, m_to_ev, m_ovr_ev;
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (!rstn) begin
      m_busy = 0; run = 0; high_n = -1; low_n = -1;
      e_start = 0; e_oe = 0; e_valid = 0; e_busy = 0; e_to = 0; e_ovr = 0;
      e_dout = '0;
      model_live = 1;
    end else begin
      m_tick = (run > 0) && (run % PERIOD == 0);
      run = auto_en ? run + 1 : 0;
      m_req = trig || m_tick;
      m_was_busy = m_busy;
      m_ovr_ev = m_req && m_was_busy;
      m_to_ev = 0;
      e_valid = 0;
      if (!m_was_busy) begin
        if (m_req) begin
          m_busy = 1; acc_n = edge_n; low_n = -1; high_n = -1;
        end
      end else if (high_n >= 0) begin
        if (edge_n == high_n + OE_CYC) begin
          e_valid = 1; e_dout = aif.adc_din;
        end else if (edge_n == high_n + OE_CYC + 1) begin
          m_busy = 0;
        end
      end else if (edge_n > acc_n + START_CYC) begin
        if (low_n < 0 && !aif.eoc) low_n = edge_n;
        else if (low_n >= 0 && aif.eoc) high_n = edge_n;
        else if (edge_n - (acc_n + START_CYC) >= TIMEOUT_CYC) begin
          m_to_ev = 1; m_busy = 0;
        end
      end
      e_start = m_busy && (high_n < 0) && (edge_n < acc_n + START_CYC);
      e_oe    = m_busy && (high_n >= 0) && (edge_n < high_n + OE_CYC);
      e_busy  = m_busy;
      e_to    = m_to_ev  ? 1'b1 : clr ? 1'b0 : e_to;
      e_ovr   = m_ovr_ev ? 1'b1 : clr ? 1'b0 : e_ovr;
    end
  end

  // Per-cycle compare plus event bookkeeping for the directed checks.
  int cnt_start = 0, cnt_oe = 0, n_valid = 0;
  int valid_edges[$];
  int fall_edge = -1, to_edge = -1;
  bit prev_s = 0, prev_to = 0;
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      chk("start", aif.start, e_start);
      chk("oe", aif.oe, e_oe);
      chk("dout_valid", dout_valid, e_valid);
      chk("dout", dout, e_dout);
      chk("busy", busy, e_busy);
      chk("timeout_err", timeout_err, e_to);
      chk("overrun", overrun, e_ovr);
      chk("start_oe_excl", aif.start & aif.oe, 0);
      cnt_start += int'(aif.start);
      cnt_oe    += int'(aif.oe);
      if (dout_valid) begin
        n_valid++;
        valid_edges.push_back(edge_n);
      end
      if (prev_s && !aif.start) fall_edge = edge_n;
      if (!prev_to && timeout_err) to_edge = edge_n;
      prev_s  = aif.start;
      prev_to = timeout_err;
    end
  end

  int t_edge;

  task automatic pulse_trig();
    @(posedge clk); #1;
    trig = 1'b1;
    t_edge = edge_n + 1;
    @(posedge clk); #1;
    trig = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, budget);
    end
  endtask

  task automatic wait_sig_oe(input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (!aif.oe && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!aif.oe) begin
      checks++; errors++;
      $display("FAIL %s: oe still 0 after %0d cycles, required 1", nm, budget);
    end
  endtask

  task automatic wait_sig_valid(input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (!dout_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!dout_valid) begin
      checks++; errors++;
      $display("FAIL %s: dout_valid still 0 after %0d cycles, required 1", nm, budget);
    end
  endtask

  int s_start, s_oe, s_nv;

  initial begin
    rstn = 1'b0; trig = 1'b0; auto_en = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_start", aif.start, 0);
    chk("rst_oe", aif.oe, 0);
    chk("rst_flags", {timeout_err, overrun, dout_valid}, 0);

    // Single conversion
    adc_val = 12'hA5C;
    s_start = cnt_start; s_oe = cnt_oe; s_nv = n_valid;
    pulse_trig();
    wait_idle(200, "t1_idle");
    chk("t1_start_cycles", cnt_start - s_start, 2);
    chk("t1_oe_cycles", cnt_oe - s_oe, 2);
    chk("t1_valid_count", n_valid - s_nv, 1);
    chk("t1_dout", dout, 12'hA5C);
    if (valid_edges.size() > 0) chk("t1_latency", valid_edges[$] - t_edge, 16);
    chk("t1_busy", busy, 0);

    // Periodic self-trigger
    adc_val = 12'h3C7;
    s_nv = n_valid;
    valid_edges.delete();
    @(posedge clk); #1 auto_en = 1'b1;
    repeat (520) @(posedge clk);
    #1 auto_en = 1'b0;
    wait_idle(200, "t2_idle");
    chk("t2_valid_count", n_valid - s_nv, 5);
    for (int i = 1; i < valid_edges.size(); i++)
      chk("t2_spacing", valid_edges[i] - valid_edges[i-1], PERIOD);
    chk("t2_overrun", overrun, 0);
    chk("t2_dout", dout, 12'h3C7);

    // Timeout with eoc stuck high
    adc_stuck = 1'b1;
    s_nv = n_valid;
    pulse_trig();
    wait_idle(200, "t3_idle");
    chk("t3_to_delay", to_edge - fall_edge, 64);
    chk("t3_timeout_err", timeout_err, 1);
    chk("t3_no_valid", n_valid - s_nv, 0);
    chk("t3_dout_held", dout, 12'h3C7);
    chk("t3_start_oe", {aif.start, aif.oe}, 0);
    pulse_clr();
    @(negedge clk);
    chk("t3_clr", timeout_err, 0);
    adc_stuck = 1'b0;

    // Overrun: second trig 3 cycles after the first
    adc_val = 12'h5A1;
    s_nv = n_valid;
    pulse_trig();
    repeat (2) @(posedge clk);
    #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
    @(negedge clk);
    chk("t4_overrun", overrun, 1);
    wait_idle(200, "t4_idle");
    chk("t4_valid_count", n_valid - s_nv, 1);
    chk("t4_dout", dout, 12'h5A1);
    pulse_clr();
    @(negedge clk);
    chk("t4_clr", overrun, 0);

    // Request on the GAP -> IDLE edge is dropped and flagged
    pulse_trig();
    wait_sig_valid(100, "t4_gap_valid");
    trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
    @(negedge clk);
    chk("t4_gap_overrun", overrun, 1);
    chk("t4_gap_busy", busy, 0);
    pulse_clr();

    // clr in the same cycle as a new overrun: set wins
    pulse_trig();
    repeat (2) @(posedge clk);
    #1 begin trig = 1'b1; clr = 1'b1; end
    @(posedge clk); #1 begin trig = 1'b0; clr = 1'b0; end
    @(negedge clk);
    chk("t4_set_wins", overrun, 1);
    wait_idle(200, "t4b_idle");
    pulse_clr();
    @(negedge clk);
    chk("t4b_clr", overrun, 0);

    // Reset while reading
    adc_val = 12'h1E4;
    pulse_trig();
    wait_sig_oe(100, "t5_oe");
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("t5_oe", aif.oe, 0);
    chk("t5_busy", busy, 0);
    chk("t5_dout", dout, 0);
    chk("t5_valid", dout_valid, 0);
    s_nv = n_valid;
    pulse_trig();
    wait_idle(200, "t5_idle");
    chk("t5_valid_count", n_valid - s_nv, 1);
    chk("t5_dout_after", dout, 12'h1E4);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
